// File: rtl/blink_gen_pkg.sv
// Shared encodings for the multi-channel blink generator: config mode values
// and the per-channel FSM state type.
package blink_gen_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_CONT  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/blink_channel.sv
// One blink channel: config registers, start-time latch, IDLE/RUN FSM, half-period
// counter and output gate. Burst counting and done exist only with BLINK_BURST_EN.
module blink_channel
    import blink_gen_pkg::*;
#(
    parameter int          DIV_W       = 32,
    parameter int          CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_burst,
    input  logic             start,
    input  logic             stop,
    input  logic             set_n,
    output logic             blink_out,
    output logic             done,
    output state_t           dbg_state
);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    state_t           state_q, state_d;
    logic             phase_q, phase_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] act_div_q, act_div_d;
    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] eff_div;
    logic             mode_ok;
    logic             wrap;

`ifdef BLINK_BURST_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0] act_burst_q, act_burst_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] eff_burst;
    logic             act_is_burst_q, act_is_burst_d;
    logic             done_q, done_d;

    assign eff_burst = (act_burst_q == '0) ? CNT_ONE : act_burst_q;
`else
    logic unused_burst;
    assign unused_burst = ^cfg_burst;
`endif

    // A zero divisor runs as one clock per half-period.
    assign eff_div = (act_div_q == '0) ? DIV_ONE : act_div_q;
    assign mode_ok = (mode_q == MODE_CONT) || (mode_q == MODE_BURST);
    assign wrap    = (cnt_q == eff_div - DIV_ONE);

    always_comb begin
        div_d     = div_q;
        mode_d    = mode_q;
        act_div_d = act_div_q;
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
`ifdef BLINK_BURST_EN
        burst_d        = burst_q;
        act_burst_d    = act_burst_q;
        act_is_burst_d = act_is_burst_q;
        bcnt_d         = bcnt_q;
        done_d         = 1'b0;
`endif
        if (cfg_we) begin
            div_d  = cfg_div;
            mode_d = cfg_mode;
`ifdef BLINK_BURST_EN
            burst_d = cfg_burst;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                // Latch the pre-write config so a same-cycle write waits for the next start.
                if (start && !stop && mode_ok) begin
                    state_d   = ST_RUN;
                    phase_d   = 1'b1;
                    cnt_d     = '0;
                    act_div_d = div_q;
`ifdef BLINK_BURST_EN
                    act_burst_d    = burst_q;
                    act_is_burst_d = (mode_q == MODE_BURST);
                    bcnt_d         = '0;
`endif
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    phase_d = 1'b0;
                    cnt_d   = '0;
                end else if (wrap) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
`ifdef BLINK_BURST_EN
                    // Periods are counted on the falling toggle; the burst ends at the
                    // end of the low half of the last counted period.
                    if (act_is_burst_q) begin
                        if (phase_q) begin
                            bcnt_d = bcnt_q + CNT_ONE;
                        end else if (bcnt_q == eff_burst) begin
                            state_d = ST_IDLE;
                            phase_d = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
`endif
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= 1'b0;
            cnt_q     <= '0;
            div_q     <= DIV_RST;
            mode_q    <= MODE_OFF;
            act_div_q <= DIV_RST;
`ifdef BLINK_BURST_EN
            burst_q        <= CNT_ONE;
            act_burst_q    <= CNT_ONE;
            act_is_burst_q <= 1'b0;
            bcnt_q         <= '0;
            done_q         <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
            act_div_q <= act_div_d;
`ifdef BLINK_BURST_EN
            burst_q        <= burst_d;
            act_burst_q    <= act_burst_d;
            act_is_burst_q <= act_is_burst_d;
            bcnt_q         <= bcnt_d;
            done_q         <= done_d;
`endif
        end
    end

    assign blink_out = phase_q & set_n;
    assign dbg_state = state_q;
`ifdef BLINK_BURST_EN
    assign done = done_q;
`else
    assign done = 1'b0;
`endif

endmodule

// File: rtl/blink_gen_multi.sv
// Multi-channel programmable blink generator: CH independent blink_channel copies
// sharing one config write port. Burst mode is compiled in with BLINK_BURST_EN.
module blink_gen_multi
    import blink_gen_pkg::*;
#(
    parameter int          CH          = 4,
    parameter int          DIV_W       = 32,
    parameter int unsigned DEFAULT_DIV = 25000000,
    parameter int          CNT_W       = 8,
    localparam int         CH_W        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_burst,
    input  logic [CH-1:0]    start,
    input  logic [CH-1:0]    stop,
    input  logic [CH-1:0]    set_n,
    output logic [CH-1:0]    blink_out,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    done
);
    state_t ch_state [CH];

    // Addresses at or above CH match no channel, so those writes are dropped.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic ch_we;
        assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

        blink_channel #(
            .DIV_W      (DIV_W),
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk      (clk_50MHz),
            .rst      (rst),
            .cfg_we   (ch_we),
            .cfg_div  (cfg_div),
            .cfg_mode (cfg_mode),
            .cfg_burst(cfg_burst),
            .start    (start[i]),
            .stop     (stop[i]),
            .set_n    (set_n[i]),
            .blink_out(blink_out[i]),
            .done     (done[i]),
            .dbg_state(ch_state[i])
        );

        assign busy[i] = (ch_state[i] == ST_RUN);
    end

endmodule

// File: tb/tb_blink_gen_multi.sv
// Directed bench for blink_gen_multi (3 channels so an out-of-range cfg_ch exists).
// Expectations follow BLINK_BURST_EN when the build defines it.
module tb_blink_gen_multi;
    import blink_gen_pkg::*;

    localparam int CH    = 3;
    localparam int DIV_W = 32;
    localparam int CNT_W = 8;

    logic             clk_50MHz = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_burst;
    logic [CH-1:0]    start, stop, set_n;
    logic [CH-1:0]    blink_out, busy, done;

    int total = 0;
    int bad   = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    blink_gen_multi #(
        .CH(CH), .DIV_W(DIV_W), .DEFAULT_DIV(25000000), .CNT_W(CNT_W)
    ) dut (
        .clk_50MHz(clk_50MHz), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .cfg_burst(cfg_burst),
        .start(start), .stop(stop), .set_n(set_n),
        .blink_out(blink_out), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50MHz);
        @(negedge clk_50MHz);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [31:0] div,
                             input logic [1:0] mode, input logic [7:0] burst);
        cfg_we = 1'b1; cfg_ch = ch; cfg_div = div; cfg_mode = mode; cfg_burst = burst;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input logic [CH-1:0] st, input logic [CH-1:0] sp);
        start = st; stop = sp;
        step();
        start = '0; stop = '0;
    endtask

    // k counts cycles from t+1 (k=0). burst_b=0 means free-running.
    task automatic run_check(input string tag, input int ch, input int div,
                             input int k0, input int n, input int burst_b);
        for (int k = k0; k < k0 + n; k++) begin
            logic exp_ph, exp_busy, exp_done;
            exp_busy = (burst_b == 0) || (k < 2 * burst_b * div);
            exp_ph   = exp_busy && (((k / div) % 2) == 0);
            exp_done = (burst_b != 0) && (k == 2 * burst_b * div);
            #1;
            check($sformatf("%s_out_k%0d", tag, k), blink_out[ch], exp_ph);
            check($sformatf("%s_busy_k%0d", tag, k), busy[ch], exp_busy);
            check($sformatf("%s_done_k%0d", tag, k), done[ch], exp_done);
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = '0;
        cfg_burst = '0; start = '0; stop = '0; set_n = '1;
        step(); step();
        #1;
        check("rst_out", blink_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        step();

        // Reset mode is OFF: start does nothing.
        pulse(3'b001, 3'b000);
        #1 check("off_start_busy", busy, 0);

        // CONT div=4 on ch0.
        cfg_write(2'd0, 4, MODE_CONT, 1);
        pulse(3'b001, 3'b000);
        run_check("cont0", 0, 4, 0, 16, 0);

        // Start ignored while running: pattern continues from k=16.
        pulse(3'b001, 3'b000);
        run_check("rerun0", 0, 4, 17, 4, 0);

        // stop+start same cycle: stop wins, no done.
        pulse(3'b001, 3'b001);
        #1;
        check("ss_busy", busy[0], 0);
        check("ss_out", blink_out[0], 0);
        check("ss_done", done[0], 0);
        step(); step();
        #1 check("ss_idle_busy", busy[0], 0);
        pulse(3'b001, 3'b000);
        run_check("restart0", 0, 4, 0, 6, 0);
        pulse(3'b000, 3'b001);
        #1 check("stop0_busy", busy[0], 0);

        // BURST div=3 burst=2 on ch1 (CONT without burst support).
        cfg_write(2'd1, 3, MODE_BURST, 2);
        pulse(3'b010, 3'b000);
`ifdef BLINK_BURST_EN
        run_check("burst1", 1, 3, 0, 15, 2);
`else
        run_check("burst_as_cont1", 1, 3, 0, 24, 0);
        pulse(3'b000, 3'b010);
`endif
        #1 check("burst1_end_busy", busy[1], 0);

        // set_n gating on ch2, counter keeps running.
        cfg_write(2'd2, 2, MODE_CONT, 1);
        pulse(3'b100, 3'b000);
        for (int k = 0; k < 12; k++) begin
            logic gate, exp_ph;
            gate = !(k >= 3 && k < 7);
            set_n = {gate, 2'b11};
            exp_ph = ((k / 2) % 2) == 0;
            #1;
            check($sformatf("gate_out_k%0d", k), blink_out[2], exp_ph & gate);
            check($sformatf("gate_busy_k%0d", k), busy[2], 1);
            step();
        end
        set_n = '1;
        pulse(3'b000, 3'b100);

        // div=0, burst=0 behave as 1/1.
        cfg_write(2'd0, 0, MODE_BURST, 0);
        pulse(3'b001, 3'b000);
`ifdef BLINK_BURST_EN
        run_check("min0", 0, 1, 0, 4, 1);
`else
        run_check("min0", 0, 1, 0, 8, 0);
        pulse(3'b000, 3'b001);
`endif

        // Write to channel 3 (nonexistent) must not reach ch1.
        cfg_write(2'd1, 5, MODE_OFF, 1);
        cfg_write(2'd3, 1, MODE_CONT, 1);
        pulse(3'b010, 3'b000);
        #1 check("oor_busy1", busy[1], 0);

        // Writes during RUN wait for the next start; same-cycle write uses old value.
        cfg_write(2'd0, 4, MODE_CONT, 1);
        pulse(3'b001, 3'b000);
        run_check("pre", 0, 4, 0, 3, 0);
        cfg_write(2'd0, 2, MODE_CONT, 1);
        run_check("during", 0, 4, 4, 12, 0);
        pulse(3'b000, 3'b001);
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 6; cfg_mode = MODE_CONT; cfg_burst = 1;
        start = 3'b001;
        step();
        cfg_we = 1'b0; start = '0;
        run_check("latch", 0, 2, 0, 8, 0);
        pulse(3'b000, 3'b001);
        pulse(3'b001, 3'b000);
        run_check("newdiv", 0, 6, 0, 14, 0);

        // Asynchronous reset mid-operation.
        cfg_write(2'd1, 3, MODE_BURST, 2);
        pulse(3'b010, 3'b000);
        step();
        rst = 1'b1;
        #1;
        check("arst_out", blink_out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        step();
        rst = 1'b0;
        step();
        pulse(3'b011, 3'b000);
        #1 check("arst_cfg_off_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
